// File: rtl/router_out_reader.sv
// ============================================================================
// Module   : router_out_reader
// Purpose  : Drains one packet at a time from a router output FIFO, checking
//            parity and address and streaming the payload to a consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module router_out_reader #(
  parameter int         READ_DELAY = 5,
  parameter logic [1:0] PORT_ADDR  = 2'b00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       rd_allow,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_abort,
  output logic [5:0] pkt_len,
  output logic [7:0] pkt_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_HDR_RD  = 3'd2;
  localparam logic [2:0] S_HDR_CAP = 3'd3;
  localparam logic [2:0] S_BODY    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [4:0] C_DLY = 5'(READ_DELAY);

  logic [2:0] state_q, state_d;
  logic [4:0] dly_cnt_q, dly_cnt_d;
  logic [6:0] issue_cnt_q, issue_cnt_d;
  logic [6:0] cap_cnt_q, cap_cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [5:0] len_q, len_d;
  logic       perr_q, perr_d;
  logic       aerr_q, aerr_d;
  logic       read_enb_q, read_enb_d;
  logic       pend_q, pend_d;
  logic       abort_q, abort_d;
  logic [7:0] count_q, count_d;
  logic       byte_valid_w;

  always_comb begin
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    issue_cnt_d  = issue_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    acc_d        = acc_q;
    len_d        = len_q;
    perr_d       = perr_q;
    aerr_d       = aerr_q;
    count_d      = count_q;
    read_enb_d   = 1'b0;
    pend_d       = 1'b0;
    abort_d      = 1'b0;
    byte_valid_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vld_out) begin
          state_d   = S_WAIT;
          dly_cnt_d = 5'd0;
        end
      end

      S_WAIT: begin
        if (!vld_out) begin
          state_d = S_IDLE;
        end else begin
          // Saturate so a stalled rd_allow still finds the match later.
          if (dly_cnt_q != C_DLY) dly_cnt_d = dly_cnt_q + 5'd1;
          if (dly_cnt_q == C_DLY && rd_allow) begin
            state_d    = S_HDR_RD;
            read_enb_d = 1'b1;
          end
        end
      end

      S_HDR_RD: state_d = S_HDR_CAP;

      S_HDR_CAP: begin
        len_d     = data_out[7:2];
        acc_d     = data_out;
        aerr_d    = (data_out[1:0] != PORT_ADDR);
        cap_cnt_d = 7'd0;
        state_d   = S_BODY;
        // read_enb is registered, so the first body read is decided here.
        if (rd_allow && vld_out) begin
          read_enb_d  = 1'b1;
          issue_cnt_d = {1'b0, data_out[7:2]};
        end else begin
          issue_cnt_d = {1'b0, data_out[7:2]} + 7'd1;
        end
      end

      S_BODY: begin
        if (issue_cnt_q != 7'd0 && rd_allow && !vld_out) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          pend_d = read_enb_q;
          if (pend_q) begin
            cap_cnt_d = cap_cnt_q + 7'd1;
            if (cap_cnt_q < {1'b0, len_q}) begin
              byte_valid_w = 1'b1;
              acc_d        = acc_q ^ data_out;
            end else begin
              perr_d  = (acc_q != data_out);
              state_d = S_DONE;
            end
          end
          if (state_d == S_BODY && issue_cnt_q != 7'd0 && rd_allow && vld_out) begin
            read_enb_d  = 1'b1;
            issue_cnt_d = issue_cnt_q - 7'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (!perr_q && !aerr_q) count_d = count_q + 8'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      dly_cnt_q   <= 5'd0;
      issue_cnt_q <= 7'd0;
      cap_cnt_q   <= 7'd0;
      acc_q       <= 8'd0;
      len_q       <= 6'd0;
      perr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      read_enb_q  <= 1'b0;
      pend_q      <= 1'b0;
      abort_q     <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      perr_q      <= perr_d;
      aerr_q      <= aerr_d;
      read_enb_q  <= read_enb_d;
      pend_q      <= pend_d;
      abort_q     <= abort_d;
      count_q     <= count_d;
    end
  end

  assign read_enb   = read_enb_q;
  assign byte_valid = byte_valid_w;
  assign byte_data  = byte_valid_w ? data_out : 8'd0;
  assign pkt_done   = (state_q == S_DONE);
  assign parity_err = pkt_done & perr_q;
  assign addr_err   = pkt_done & aerr_q;
  assign pkt_abort  = abort_q;
  assign pkt_len    = len_q;
  assign pkt_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_router_out_reader.sv
// ============================================================================
// Module   : tb_router_out_reader
// Purpose  : Directed self-checking bench for router_out_reader with a FIFO model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_router_out_reader;

  localparam int RD = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'd0;
  logic       rd_allow;
  logic       read_enb;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;
  logic [5:0] pkt_len;
  logic [7:0] pkt_count;

  router_out_reader #(.READ_DELAY(RD), .PORT_ADDR(2'b00)) dut (
    .clk(clk), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
    .rd_allow(rd_allow), .read_enb(read_enb), .byte_valid(byte_valid),
    .byte_data(byte_data), .pkt_done(pkt_done), .parity_err(parity_err),
    .addr_err(addr_err), .pkt_abort(pkt_abort), .pkt_len(pkt_len),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data and non-empty flag
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (read_enb && fifo_q.size() != 0) data_out <= fifo_q.pop_front();
    vld_out <= (fifo_q.size() != 0);
  end

  int         n_rd, n_bv, n_done, n_abort, run, max_run;
  logic       got_perr, got_aerr;
  logic [5:0] got_len;
  logic [7:0] bytes[$];

  always @(negedge clk) begin
    if (resetn) begin
      if (read_enb) begin
        n_rd++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (byte_valid) begin
        n_bv++;
        bytes.push_back(byte_data);
      end
      if (pkt_done) begin
        n_done++;
        got_perr = parity_err;
        got_aerr = addr_err;
        got_len  = pkt_len;
      end
      if (pkt_abort) n_abort++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_rd = 0; n_bv = 0; n_done = 0; n_abort = 0; run = 0; max_run = 0;
    got_perr = 1'b0; got_aerr = 1'b0; got_len = 6'd0;
    bytes.delete();
  endtask

  task automatic send_pkt(input int len, input logic [7:0] hdr, input logic [7:0] par);
    clr_mon();
    fifo_q.push_back(hdr);
    for (int i = 0; i < len; i++) fifo_q.push_back(8'((i + 1) * 17));
    fifo_q.push_back(par);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (n_done == 0 && n_abort == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 32'(k < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_payload(input string tag);
    check({tag, "_nbv"}, 32'(n_bv), 32'd3);
    if (n_bv == 3) begin
      check({tag, "_b0"}, 32'(bytes[0]), 32'h11);
      check({tag, "_b1"}, 32'(bytes[1]), 32'h22);
      check({tag, "_b2"}, 32'(bytes[2]), 32'h33);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    resetn   = 1'b0;
    rd_allow = 1'b1;
    clr_mon();
    repeat (3) @(negedge clk);
    check("rst_read_enb", 32'(read_enb), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Good packet with header-latency measurement
    send_pkt(3, 8'h0C, 8'h0C);
    k = 0;
    while (!read_enb && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("good_hdr_latency", 32'(k), 32'(RD + 3));
    wait_end("good");
    check("good_nrd", 32'(n_rd), 32'd5);
    check("good_body_run", 32'(max_run), 32'd4);
    check_payload("good");
    check("good_done", 32'(n_done), 32'd1);
    check("good_perr", 32'(got_perr), 32'd0);
    check("good_aerr", 32'(got_aerr), 32'd0);
    check("good_len", 32'(got_len), 32'd3);
    check("good_count", 32'(pkt_count), 32'd1);
    check("good_abort", 32'(n_abort), 32'd0);

    // Bad parity
    send_pkt(3, 8'h0C, 8'h0D);
    wait_end("badpar");
    check("badpar_done", 32'(n_done), 32'd1);
    check("badpar_perr", 32'(got_perr), 32'd1);
    check("badpar_aerr", 32'(got_aerr), 32'd0);
    check("badpar_count", 32'(pkt_count), 32'd1);

    // Backpressure for 4 cycles after the first payload byte
    send_pkt(3, 8'h0C, 8'h0C);
    k = 0;
    while (n_bv == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    rd_allow = 1'b0;
    repeat (4) @(negedge clk);
    rd_allow = 1'b1;
    wait_end("bp");
    check("bp_nrd", 32'(n_rd), 32'd5);
    check("bp_split", 32'(max_run < 4), 32'd1);
    check_payload("bp");
    check("bp_perr", 32'(got_perr), 32'd0);
    check("bp_count", 32'(pkt_count), 32'd2);

    // Abort: FIFO runs dry after two payload bytes
    clr_mon();
    fifo_q.push_back(8'h0C);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    wait_end("abort");
    check("abort_pulse", 32'(n_abort), 32'd1);
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_count", 32'(pkt_count), 32'd2);
    send_pkt(3, 8'h0C, 8'h0C);
    wait_end("post_abort");
    check_payload("post_abort");
    check("post_abort_perr", 32'(got_perr), 32'd0);
    check("post_abort_count", 32'(pkt_count), 32'd3);

    // Zero length, wrong address
    send_pkt(0, 8'h01, 8'h01);
    wait_end("zlen");
    check("zlen_nbv", 32'(n_bv), 32'd0);
    check("zlen_nrd", 32'(n_rd), 32'd2);
    check("zlen_done", 32'(n_done), 32'd1);
    check("zlen_perr", 32'(got_perr), 32'd0);
    check("zlen_aerr", 32'(got_aerr), 32'd1);
    check("zlen_len", 32'(got_len), 32'd0);
    check("zlen_count", 32'(pkt_count), 32'd3);

    // Asynchronous reset mid-body
    send_pkt(3, 8'h0C, 8'h0C);
    k = 0;
    while (n_bv == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    #2;
    resetn = 1'b0;
    fifo_q.delete();
    #1;
    check("arst_read_enb", 32'(read_enb), 32'd0);
    check("arst_byte_valid", 32'(byte_valid), 32'd0);
    check("arst_byte_data", 32'(byte_data), 32'd0);
    check("arst_pkt_done", 32'(pkt_done), 32'd0);
    check("arst_pkt_abort", 32'(pkt_abort), 32'd0);
    check("arst_pkt_len", 32'(pkt_len), 32'd0);
    check("arst_pkt_count", 32'(pkt_count), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clr_mon();
    repeat (20) @(negedge clk);
    check("arst_quiet_done", 32'(n_done), 32'd0);
    check("arst_quiet_abort", 32'(n_abort), 32'd0);
    check("arst_quiet_rd", 32'(n_rd), 32'd0);

    // 256 good packets wrap the counter
    for (int p = 0; p < 256; p++) begin
      send_pkt(0, 8'h00, 8'h00);
      wait_end("wrap");
      if (p == 254) check("wrap_255", 32'(pkt_count), 32'd255);
    end
    check("wrap_0", 32'(pkt_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/router_out_reader.md
# router_out_reader

Destination-side reader for one output port of the 1x3 router. It watches the port's `vld_out`, asserts `read_enb` within the soft-reset window, and drains one packet at a time from the output FIFO. Each packet is a header byte (length in [7:2], address in [1:0]), `len` payload bytes, then a parity byte. The block re-checks parity and address, streams payload to a local consumer, and reports completion, errors and aborts. One instance sits on each of the router's three output ports (0/1/2).

## Interface
- `READ_DELAY`, default 5: cycles to wait after `vld_out` is seen high before the header read. Legal range 0..25, which keeps the header read inside the 30-cycle soft-reset window.
- `PORT_ADDR`, default 2'b00: address this port expects in header[1:0].

- `clk` in 1: single clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `vld_out` in 1: FIFO non-empty for this port.
- `data_out` in 8: FIFO read data, valid the cycle after `read_enb`.
- `rd_allow` in 1: consumer backpressure; low blocks issuing new reads.
- `read_enb` out 1: registered FIFO read strobe.
- `byte_valid` out 1: `byte_data` holds a payload byte this cycle.
- `byte_data` out 8: payload byte.
- `pkt_done` out 1: one-cycle pulse after the parity byte is captured.
- `parity_err` out 1: valid with `pkt_done`; computed parity ≠ received parity.
- `addr_err` out 1: valid with `pkt_done`; header[1:0] ≠ `PORT_ADDR`.
- `pkt_abort` out 1: one-cycle pulse; packet dropped mid-read.
- `pkt_len` out 6: length of the last header captured; held until the next header.
- `pkt_count` out 8: count of good packets (`pkt_done` with both errors clear); wraps 255→0.

## Operation
- Reset (async, `resetn`=0):
  - FSM goes to IDLE.
  - All outputs and internal counters go to 0, including `pkt_len` and `pkt_count`.
  - Reset asserted mid-packet discards everything; no pulse is generated.
- FSM states: IDLE, WAIT, HDR_RD, HDR_CAP, BODY, DONE.
- IDLE: if `vld_out`=1, go to WAIT with `dly_cnt`=0.
- WAIT:
  - If `vld_out`=0, return to IDLE silently (no pulse).
  - Otherwise increment `dly_cnt`. When `dly_cnt`==`READ_DELAY` and `rd_allow`=1, go to HDR_RD.
- HDR_RD: `read_enb`=1 for exactly one cycle, then go to HDR_CAP.
- HDR_CAP: `read_enb`=0.
  - Capture `data_out` as the header: `pkt_len`=header[7:2], parity accumulator = header, addr mismatch flag latched.
  - Set `issue_cnt`=`len`+1 and `cap_cnt`=0.
  - Go to BODY.
- BODY:
  - Issuing: `read_enb`=1 in each cycle where `issue_cnt`≠0, `rd_allow`=1 and `vld_out`=1. Each issue decrements `issue_cnt`.
  - Capturing: in the cycle after each issued read, `data_out` is captured and `cap_cnt` increments.
    - Captures 1..`len` are payload: `byte_valid`=1 and `byte_data`=byte in the same cycle, and the byte is XORed into the accumulator.
    - Capture `len`+1 is the parity byte; it is compared with the accumulator, then the FSM goes to DONE.
  - Abort: if `vld_out`=0 while `issue_cnt`≠0 and `rd_allow`=1, pulse `pkt_abort`, deassert `read_enb`, and go to IDLE. No `pkt_done` is generated and any in-flight return byte is ignored.
- DONE:
  - Pulse `pkt_done` together with `parity_err` and `addr_err`.
  - Increment `pkt_count` if both errors are clear (8-bit wrap).
  - Go to IDLE. If `vld_out` is still high, the next packet's WAIT starts from IDLE on the following cycle.
- `len`=0: no payload and no `byte_valid`; one parity read. Parity expected = header.
- `rd_allow` low in any state only stalls issuing; captures of reads already issued still complete. A stall longer than the FIFO soft-reset window makes `vld_out` fall, which triggers the abort path.

## Timing
- Let `vld_out` be first sampled high at edge t0, with `rd_allow` held high throughout.
  - WAIT runs from t0+1.
  - Header `read_enb` is high in cycle t0+READ_DELAY+2.
  - Header is captured the next cycle.
  - Body reads are back-to-back for `len`+1 cycles, starting the cycle after HDR_CAP.
- `byte_valid` lags the matching `read_enb` by exactly 1 cycle.
- `pkt_done` comes 1 cycle after the parity capture.
- Total `read_enb` high cycles per packet = `len`+2.
- Packet-to-packet gap is at least READ_DELAY+3 cycles.
- `read_enb` is never high for more than `len`+2 cycles per packet and never high in IDLE, WAIT, HDR_CAP or DONE.

## Test plan
- **Reset:** pulse `resetn` low mid-BODY, asynchronously → all outputs 0 immediately; FSM in IDLE; no `pkt_done` or `pkt_abort`.
- **Good packet:** `READ_DELAY`=5, `PORT_ADDR`=0, FIFO holds 0x0C, 0x11, 0x22, 0x33, 0x0C → `read_enb` high 1 cycle (header) then 4 consecutive cycles; `byte_valid`×3 with 0x11/0x22/0x33; `pkt_done`=1, `parity_err`=0, `addr_err`=0, `pkt_len`=3, `pkt_count`=1.
- **Bad parity:** same packet but parity byte 0x0D → `pkt_done` with `parity_err`=1; `pkt_count` unchanged.
- **Backpressure:** drop `rd_allow` for 4 cycles after the first payload byte → `read_enb` low for those 4 cycles; payload still 0x11/0x22/0x33 in order, no duplicate or lost byte; `parity_err`=0.
- **Abort:** force `vld_out`=0 after 2 payload reads → `pkt_abort` pulse; no `pkt_done`; FSM returns to IDLE; the next good packet completes normally.
- **Zero length, wrong address:** `PORT_ADDR`=0, FIFO holds 0x01, 0x01 → no `byte_valid`; `pkt_done` with `parity_err`=0, `addr_err`=1, `pkt_len`=0. Separately, 256 good packets → `pkt_count` wraps back to 0.
